// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared board geometry and sequencer state encoding
package board_pkg;

  localparam int ROWS   = 20;
  localparam int COLS   = 10;
  localparam int LINE_W = 10;

  localparam logic [COLS-1:0] ROW_FULL = {COLS{1'b1}};

  typedef logic [3:0] state_t;

  localparam logic [3:0] ST_CLEAR   = 4'd0;
  localparam logic [3:0] ST_IDLE    = 4'd1;
  localparam logic [3:0] ST_MRG_RD  = 4'd2;
  localparam logic [3:0] ST_MRG_WR  = 4'd3;
  localparam logic [3:0] ST_SCN_RD  = 4'd4;
  localparam logic [3:0] ST_SCN_CHK = 4'd5;
  localparam logic [3:0] ST_SH_RD   = 4'd6;
  localparam logic [3:0] ST_SH_WR   = 4'd7;
  localparam logic [3:0] ST_SH_TOP  = 4'd8;
  localparam logic [3:0] ST_DONE    = 4'd9;

endpackage

// File: rtl/piece_row_mask.sv
// rtl/piece_row_mask.sv - maps one 4-wide piece row onto a board row word
module piece_row_mask
  import board_pkg::*;
#(
  parameter int ROWS = board_pkg::ROWS,
  parameter int COLS = board_pkg::COLS
) (
  input  logic [15:0]     set_space,
  input  logic [1:0]      i,
  input  logic [4:0]      set_row,
  input  logic [3:0]      set_col,
  output logic [COLS-1:0] mask,
  output logic [4:0]      row,
  output logic            row_valid
);

  logic [3:0] bits;
  logic [4:0] col [4];

  // Anchor sits at piece cell (2,2); offsets wrap in 5 bits so anything left
  // of / below the board lands at a large value and falls out of range.
  always_comb begin
    bits      = set_space[{i, 2'b00} +: 4];
    row       = set_row + {3'b000, i} - 5'd2;
    row_valid = (row < 5'(ROWS));
    mask      = '0;
    for (int j = 0; j < 4; j++) begin
      col[j] = {1'b0, set_col} + 5'(j) - 5'd2;
    end
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < COLS; c++) begin
        if (bits[j] && (col[j] == 5'(c))) begin
          mask[c] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/board_commit_sequencer.sv
// rtl/board_commit_sequencer.sv - merges locked pieces, clears full lines, owns board writes
module board_commit_sequencer
  import board_pkg::*;
#(
  parameter int ROWS   = board_pkg::ROWS,
  parameter int COLS   = board_pkg::COLS,
  parameter int LINE_W = board_pkg::LINE_W
) (
  input  logic              refreshClock,
  input  logic              reset,
  input  logic              setSignal,
  input  logic [15:0]       set_space,
  input  logic [4:0]        setRow,
  input  logic [3:0]        setCol,
  input  logic [4:0]        probe_row,
  output logic [4:0]        mem_rd_row,
  input  logic [COLS-1:0]   mem_rd_data,
  output logic              mem_wr_en,
  output logic [4:0]        mem_wr_row,
  output logic [COLS-1:0]   mem_wr_data,
  output logic              busy,
  output logic [2:0]        lines_cleared,
  output logic              done,
  output logic [LINE_W-1:0] lines_total,
  output logic              overrun
);

  localparam logic [COLS-1:0] FULL = {COLS{1'b1}};

  state_t      state;
  logic        rst_q;
  logic [4:0]  clr_row;
  logic [1:0]  idx;
  logic [4:0]  scan_row;
  logic [4:0]  shift_row;
  logic [2:0]  clear_cnt;
  logic [15:0] p_space;
  logic [4:0]  p_row;
  logic [3:0]  p_col;

  logic [COLS-1:0] mask;
  logic [4:0]      brd_row;
  logic            row_valid;

  piece_row_mask #(.ROWS(ROWS), .COLS(COLS)) u_mask (
    .set_space (p_space),
    .i         (idx),
    .set_row   (p_row),
    .set_col   (p_col),
    .mask      (mask),
    .row       (brd_row),
    .row_valid (row_valid)
  );

  // Sequencer state, piece latch and line statistics.
  always_ff @(posedge refreshClock) begin
    if (reset) begin
      state         <= ST_CLEAR;
      rst_q         <= 1'b1;
      clr_row       <= '0;
      idx           <= '0;
      scan_row      <= '0;
      shift_row     <= '0;
      clear_cnt     <= '0;
      p_space       <= '0;
      p_row         <= '0;
      p_col         <= '0;
      lines_cleared <= '0;
      lines_total   <= '0;
      overrun       <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      if (setSignal && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_CLEAR: begin
          // First cycle out of reset writes nothing, so hold the row there.
          if (!rst_q) begin
            if (clr_row == 5'(ROWS - 1)) begin
              state <= ST_IDLE;
            end else begin
              clr_row <= clr_row + 5'd1;
            end
          end
        end
        ST_IDLE: begin
          if (setSignal) begin
            p_space <= set_space;
            p_row   <= setRow;
            p_col   <= setCol;
            idx     <= '0;
            state   <= ST_MRG_RD;
          end
        end
        ST_MRG_RD: state <= ST_MRG_WR;
        ST_MRG_WR: begin
          if (idx == 2'd3) begin
            scan_row  <= '0;
            clear_cnt <= '0;
            state     <= ST_SCN_RD;
          end else begin
            idx   <= idx + 2'd1;
            state <= ST_MRG_RD;
          end
        end
        ST_SCN_RD: state <= ST_SCN_CHK;
        ST_SCN_CHK: begin
          if (mem_rd_data == FULL) begin
            clear_cnt <= clear_cnt + 3'd1;
            shift_row <= scan_row;
            // A full top row has nothing above it to pull down.
            state     <= (scan_row == 5'(ROWS - 1)) ? ST_SH_TOP : ST_SH_RD;
          end else if (scan_row == 5'(ROWS - 1)) begin
            lines_cleared <= clear_cnt;
            lines_total   <= lines_total + LINE_W'(clear_cnt);
            state         <= ST_DONE;
          end else begin
            scan_row <= scan_row + 5'd1;
            state    <= ST_SCN_RD;
          end
        end
        ST_SH_RD: state <= ST_SH_WR;
        ST_SH_WR: begin
          if (shift_row == 5'(ROWS - 2)) begin
            state <= ST_SH_TOP;
          end else begin
            shift_row <= shift_row + 5'd1;
            state     <= ST_SH_RD;
          end
        end
        ST_SH_TOP: state <= ST_SCN_RD;
        ST_DONE:   state <= ST_IDLE;
        default:   state <= ST_CLEAR;
      endcase
    end
  end

  // Read-port arbitration: the game controller's probe owns it only while idle.
  always_comb begin
    case (state)
      ST_MRG_RD: mem_rd_row = brd_row;
      ST_SCN_RD: mem_rd_row = scan_row;
      ST_SH_RD:  mem_rd_row = shift_row + 5'd1;
      default:   mem_rd_row = probe_row;
    endcase
  end

  // Board write port, driven in the cycle the write belongs to.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_row  = '0;
    mem_wr_data = '0;
    case (state)
      ST_CLEAR: begin
        mem_wr_en  = !rst_q;
        mem_wr_row = clr_row;
      end
      ST_MRG_WR: begin
        mem_wr_en   = row_valid && (mask != '0);
        mem_wr_row  = brd_row;
        mem_wr_data = mem_rd_data | mask;
      end
      ST_SH_WR: begin
        mem_wr_en   = 1'b1;
        mem_wr_row  = shift_row;
        mem_wr_data = mem_rd_data;
      end
      ST_SH_TOP: begin
        mem_wr_en  = 1'b1;
        mem_wr_row = 5'(ROWS - 1);
      end
      default: ;
    endcase
  end

  // Status strobes derived from state.
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_board_commit_sequencer.sv
// tb/tb_board_commit_sequencer.sv - directed self-checking bench for board_commit_sequencer
module tb_board_commit_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        set_sig;
  logic [15:0] set_space;
  logic [4:0]  set_row;
  logic [3:0]  set_col;
  logic [4:0]  probe_row;
  logic [4:0]  rd_row;
  logic [9:0]  rd_data;
  logic        wr_en;
  logic [4:0]  wr_row;
  logic [9:0]  wr_data;
  logic        busy;
  logic [2:0]  lines_cleared;
  logic        done;
  logic [9:0]  lines_total;
  logic        overrun;

  logic [9:0]  mem [20];
  logic        pre_en;
  logic [4:0]  pre_row;
  logic [9:0]  pre_data;

  int errors = 0;
  int checks = 0;
  int cyc;

  always #5 clk = ~clk;

  board_commit_sequencer dut (
    .refreshClock  (clk),
    .reset         (reset),
    .setSignal     (set_sig),
    .set_space     (set_space),
    .setRow        (set_row),
    .setCol        (set_col),
    .probe_row     (probe_row),
    .mem_rd_row    (rd_row),
    .mem_rd_data   (rd_data),
    .mem_wr_en     (wr_en),
    .mem_wr_row    (wr_row),
    .mem_wr_data   (wr_data),
    .busy          (busy),
    .lines_cleared (lines_cleared),
    .done          (done),
    .lines_total   (lines_total),
    .overrun       (overrun)
  );

  // Board RAM model: synchronous read, bench preload port has priority.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_row] <= pre_data;
    end else if (wr_en && (wr_row < 5'd20)) begin
      mem[wr_row] <= wr_data;
    end
    rd_data <= (rd_row < 5'd20) ? mem[rd_row] : 10'h000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_row(input int r, input logic [9:0] d);
    pre_en   = 1'b1;
    pre_row  = 5'(r);
    pre_data = d;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic start_commit(input logic [15:0] sp, input logic [4:0] r, input logic [3:0] c);
    set_sig   = 1'b1;
    set_space = sp;
    set_row   = r;
    set_col   = c;
    @(negedge clk);
    set_sig   = 1'b0;
    cyc       = 1;
  endtask

  task automatic wait_done();
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; set_sig = 1'b0; set_space = '0; set_row = '0; set_col = '0;
    probe_row = '0; pre_en = 1'b0; pre_row = '0; pre_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_lines_cleared", {29'd0, lines_cleared}, 32'd0);
    chk("rst_lines_total", {22'd0, lines_total}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);

    reset = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      chk($sformatf("clr_en_c%0d", c), {31'd0, wr_en}, (c <= 20) ? 32'd1 : 32'd0);
      chk($sformatf("clr_busy_c%0d", c), {31'd0, busy}, (c <= 20) ? 32'd1 : 32'd0);
      if (c <= 20) begin
        chk($sformatf("clr_row_c%0d", c), {27'd0, wr_row}, 32'(c - 1));
        chk($sformatf("clr_data_c%0d", c), {22'd0, wr_data}, 32'd0);
      end
    end

    probe_row = 5'd3;
    #1;
    chk("probe_pass", {27'd0, rd_row}, 32'd3);
    chk("probe_busy", {31'd0, busy}, 32'd0);
    chk("probe_no_wr", {31'd0, wr_en}, 32'd0);
    @(negedge clk);

    start_commit(16'h0660, 5'd1, 4'd5);
    chk("a_busy_rise", {31'd0, busy}, 32'd1);
    wait_done();
    chk("a_done_cycle", 32'(cyc), 32'd49);
    chk("a_lines_cleared", {29'd0, lines_cleared}, 32'd0);
    chk("a_row0", {22'd0, mem[0]}, 32'h030);
    chk("a_row1", {22'd0, mem[1]}, 32'h030);
    chk("a_row2", {22'd0, mem[2]}, 32'h000);
    @(negedge clk);
    chk("a_done_pulse", {31'd0, done}, 32'd0);
    chk("a_busy_fall", {31'd0, busy}, 32'd0);

    load_row(0, 10'h3CF);
    for (int r = 1; r < 20; r++) load_row(r, 10'h000);
    start_commit(16'h0660, 5'd1, 4'd5);
    wait_done();
    chk("b_done_cycle", 32'(cyc), 32'd90);
    chk("b_lines_cleared", {29'd0, lines_cleared}, 32'd1);
    chk("b_lines_total", {22'd0, lines_total}, 32'd1);
    @(negedge clk);
    chk("b_row0", {22'd0, mem[0]}, 32'h030);
    chk("b_row1", {22'd0, mem[1]}, 32'h000);
    chk("b_row19", {22'd0, mem[19]}, 32'h000);

    for (int r = 0; r < 20; r++) load_row(r, (r < 3) ? 10'h3FE : 10'h000);
    start_commit(16'h2222, 5'd1, 4'd1);
    wait_done();
    chk("c_done_cycle", 32'(cyc), 32'd172);
    chk("c_lines_cleared", {29'd0, lines_cleared}, 32'd3);
    chk("c_lines_total", {22'd0, lines_total}, 32'd4);
    @(negedge clk);
    for (int r = 0; r < 20; r++) chk($sformatf("c_row%0d", r), {22'd0, mem[r]}, 32'h000);
    chk("c_lines_hold", {29'd0, lines_cleared}, 32'd3);

    for (int r = 0; r < 3; r++) load_row(r, 10'h3FE);
    start_commit(16'h2222, 5'd1, 4'd1);
    while (cyc < 15) begin
      @(negedge clk);
      cyc++;
    end
    chk("d_overrun_before", {31'd0, overrun}, 32'd0);
    set_sig = 1'b1;
    set_space = 16'hFFFF;
    @(negedge clk);
    set_sig = 1'b0;
    chk("d_overrun_set", {31'd0, overrun}, 32'd1);
    chk("d_mid_shift_wr", {31'd0, wr_en}, 32'd1);
    chk("d_mid_shift_row", {27'd0, wr_row}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("d_rst_no_wr", {31'd0, wr_en}, 32'd0);
    chk("d_rst_overrun", {31'd0, overrun}, 32'd0);
    chk("d_rst_busy", {31'd0, busy}, 32'd1);
    chk("d_rst_total", {22'd0, lines_total}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("d_clr_restart_en", {31'd0, wr_en}, 32'd1);
    chk("d_clr_restart_row", {27'd0, wr_row}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
